generator: RTL and testbench

GENERATOR -- requirements
Module: generator

---
 rtl/generator.sv | 105 ++++++++++
 tb/tb_generator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/generator.sv
// Midpoint-circle point generator: after a start request, emits the eight
// symmetric points of each octant step, one point per clock, then reports done.
module generator (
  input  logic               _clock,
  input  logic               _reset_n,
  input  logic               _start,
  input  logic signed [31:0] s_x,
  input  logic signed [31:0] s_y,
  input  logic signed [31:0] height,
  output logic signed [31:0] _out0,
  output logic signed [31:0] _out1,
  output logic               _valid,
  output logic               _done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [31:0] sx, sy, x, y, d;
  logic        [2:0]  k;

  logic signed [31:0] off_a, off_b, pt_x, pt_y;
  logic signed [31:0] x_inc, y_dec;
  logic               loop_go;

  // The group index k selects a swap of x/y (bit 2) and the sign on each axis.
  always_comb begin
    off_a   = k[2] ? y : x;
    off_b   = k[2] ? x : y;
    pt_x    = k[1] ? (sx - off_a) : (sx + off_a);
    pt_y    = k[0] ? (sy - off_b) : (sy + off_b);
    x_inc   = x + 32'sd1;
    y_dec   = y - 32'sd1;
    loop_go = (y >= x);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (_start) state_nxt = RUN;
      RUN:        if ((k == 3'd7) && !loop_go) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      sx     <= '0;
      sy     <= '0;
      x      <= '0;
      y      <= '0;
      d      <= '0;
      k      <= '0;
      _out0  <= '0;
      _out1  <= '0;
      _valid <= 1'b0;
      _done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          _valid <= 1'b0;
          if (_start) begin
            sx    <= s_x;
            sy    <= s_y;
            x     <= '0;
            y     <= height;
            d     <= 32'sd3 - (height <<< 1);
            k     <= '0;
            _done <= 1'b0;
          end else begin
            _done <= (state == DONE);
          end
        end
        RUN: begin
          _out0  <= pt_x;
          _out1  <= pt_y;
          _valid <= 1'b1;
          k      <= k + 3'd1;
          // Advance the octant walk only after the eighth point of a group.
          if ((k == 3'd7) && loop_go) begin
            x <= x_inc;
            if (d > 32'sd0) begin
              y <= y_dec;
              d <= d + ((x_inc - y_dec) <<< 2) + 32'sd10;
            end else begin
              d <= d + (x_inc <<< 2) + 32'sd6;
            end
          end
        end
        default: _valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_generator.sv
// Bench for the midpoint-circle generator: a point-list model built from the
// algorithm description is compared point by point against the DUT output.
module tb_generator;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [31:0] sx_in, sy_in, h_in;
  logic signed [31:0] out0, out1;
  logic               valid, done;

  int checks   = 0;
  int failures = 0;
  int ex[$];
  int ey[$];

  int nom_x[24] = '{23,23,23,23,28,28,18,18, 24,24,22,22,28,28,18,18,
                    27,27,19,19,25,25,21,21};
  int nom_y[24] = '{22,12,22,12,17,17,17,17, 22,12,22,12,18,16,18,16,
                    19,15,19,15,21,13,21,13};

  generator dut (
    ._clock  (clk),
    ._reset_n(rst_n),
    ._start  (start),
    .s_x     (sx_in),
    .s_y     (sy_in),
    .height  (h_in),
    ._out0   (out0),
    ._out1   (out1),
    ._valid  (valid),
    ._done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected point list straight from the algorithm, using 32-bit int wrap.
  function automatic void build_model(input int cx, input int cy, input int h);
    int x, y, d;
    ex.delete();
    ey.delete();
    x = 0;
    y = h;
    d = 3 - 2 * h;
    forever begin
      ex.push_back(cx + x); ey.push_back(cy + y);
      ex.push_back(cx + x); ey.push_back(cy - y);
      ex.push_back(cx - x); ey.push_back(cy + y);
      ex.push_back(cx - x); ey.push_back(cy - y);
      ex.push_back(cx + y); ey.push_back(cy + x);
      ex.push_back(cx + y); ey.push_back(cy - x);
      ex.push_back(cx - y); ey.push_back(cy + x);
      ex.push_back(cx - y); ey.push_back(cy - x);
      if (!(y >= x)) break;
      x = x + 1;
      if (d > 0) begin
        y = y - 1;
        d = d + 4 * (x - y) + 10;
      end else begin
        d = d + 4 * x + 6;
      end
    end
  endfunction

  task automatic pulse_start(input int cx, input int cy, input int h);
    @(negedge clk);
    sx_in = cx;
    sy_in = cy;
    h_in  = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    sx_in = '0;
    sy_in = '0;
    h_in  = '0;
    #23;
    checks++;
    if (out0 !== 32'sd0 || out1 !== 32'sd0 || valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset got (%0d,%0d,v=%0b,d=%0b) want (0,0,v=0,d=0)", out0, out1, valid, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle got v=%0b d=%0b want v=0 d=0", valid, done);
    end
  endtask

  task automatic test_nominal;
    build_model(23, 17, 5);
    checks++;
    if (ex.size() != 40) begin
      failures++;
      $display("FAIL nominal_len got %0d want 40", ex.size());
    end
    pulse_start(23, 17, 5);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL nominal_accept got v=%0b want v=0", valid);
    end
    for (int i = 0; i < 40; i++) begin
      int wx, wy;
      @(negedge clk);
      wx = (i < 16) ? nom_x[i] : (i >= 32) ? nom_x[i - 16] : ex[i];
      wy = (i < 16) ? nom_y[i] : (i >= 32) ? nom_y[i - 16] : ey[i];
      checks++;
      if (valid !== 1'b1 || out0 !== wx || out1 !== wy || done !== 1'b0) begin
        failures++;
        $display("FAIL nominal[%0d] got (%0d,%0d,v=%0b,d=%0b) want (%0d,%0d,v=1,d=0)",
                 i, out0, out1, valid, done, wx, wy);
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || done !== 1'b1 || out0 !== 32'sd21 || out1 !== 32'sd13) begin
        failures++;
        $display("FAIL nominal_done got (%0d,%0d,v=%0b,d=%0b) want (21,13,v=0,d=1)",
                 out0, out1, valid, done);
      end
    end
  endtask

  task automatic test_edges;
    int hs[2] = '{0, -3};
    int ns[2] = '{16, 8};
    for (int t = 0; t < 2; t++) begin
      build_model(0, 0, hs[t]);
      pulse_start(0, 0, hs[t]);
      checks++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL edge_restart h=%0d got v=%0b d=%0b want v=0 d=0", hs[t], valid, done);
      end
      for (int i = 0; i < ns[t]; i++) begin
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || out0 !== ex[i] || out1 !== ey[i]) begin
          failures++;
          $display("FAIL edge h=%0d [%0d] got (%0d,%0d,v=%0b) want (%0d,%0d,v=1)",
                   hs[t], i, out0, out1, valid, ex[i], ey[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || done !== 1'b1) begin
        failures++;
        $display("FAIL edge_count h=%0d got v=%0b d=%0b want v=0 d=1 after %0d points",
                 hs[t], valid, done, ns[t]);
      end
    end
  endtask

  task automatic test_start_in_run;
    build_model(-40, 100, 7);
    pulse_start(-40, 100, 7);
    sx_in = 32'sd999;
    sy_in = -32'sd999;
    h_in  = 32'sd3;
    for (int i = 0; i < ex.size(); i++) begin
      start = (i == 4 || i == 13);
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || out0 !== ex[i] || out1 !== ey[i]) begin
        failures++;
        $display("FAIL run_start[%0d] got (%0d,%0d,v=%0b) want (%0d,%0d,v=1)",
                 i, out0, out1, valid, ex[i], ey[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL run_start_done got v=%0b d=%0b want v=0 d=1", valid, done);
    end
  endtask

  task automatic test_random;
    repeat (4) begin
      int cx, cy, h;
      cx = $urandom;
      cy = $urandom;
      h  = $signed($urandom_range(60)) - 10;
      build_model(cx, cy, h);
      pulse_start(cx, cy, h);
      sx_in = $urandom;
      sy_in = $urandom;
      h_in  = $urandom;
      for (int i = 0; i < ex.size(); i++) begin
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || out0 !== ex[i] || out1 !== ey[i]) begin
          failures++;
          $display("FAIL random h=%0d [%0d] got (%0d,%0d,v=%0b) want (%0d,%0d,v=1)",
                   h, i, out0, out1, valid, ex[i], ey[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || done !== 1'b1 || out0 !== ex[ex.size()-1] || out1 !== ey[ey.size()-1]) begin
        failures++;
        $display("FAIL random_done h=%0d got (%0d,%0d,v=%0b,d=%0b) want held last, v=0 d=1",
                 h, out0, out1, valid, done);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    build_model(23, 17, 5);
    pulse_start(23, 17, 5);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out0 !== 32'sd0 || out1 !== 32'sd0 || valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got (%0d,%0d,v=%0b,d=%0b) want (0,0,v=0,d=0)", out0, out1, valid, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got v=%0b d=%0b want v=0 d=0", valid, done);
    end
    pulse_start(23, 17, 5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || out0 !== ex[i] || out1 !== ey[i]) begin
        failures++;
        $display("FAIL rerun[%0d] got (%0d,%0d,v=%0b) want (%0d,%0d,v=1)",
                 i, out0, out1, valid, ex[i], ey[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL rerun_done got v=%0b d=%0b want v=0 d=1", valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_edges();
    test_start_in_run();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
